branch_flag_unit: RTL and testbench
===================================

BRANCH_FLAG_UNIT -- requirements
Module: branch_flag_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, legal 1..3: cycles of flush after a taken branch.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  in  1  pipeline stall; freezes all state.
REQ-005 SHALL have port set_flags  in  1  EX instruction writes NZCV.
REQ-006 SHALL have ports alu_neg, alu_zero, alu_carry, alu_ovf  in  1 each  live EX ALU flags; alu_zero is the 64-bit zero-detect output.
REQ-007 SHALL have port br_valid  in  1  a branch is present for resolution this cycle.
REQ-008 SHALL have port br_type  in  3  br_type_t: NONE=0, B=1, BR=2, CBZ=3, CBNZ=4, B_LT=5, B_EQ=6, B_GE=7.
REQ-009 SHALL have port cbz_zero  in  1  zero-detect of the CBZ/CBNZ test register.
REQ-010 SHALL have port flags  out  4  registered {N,Z,C,V}.
REQ-011 SHALL have port br_taken  out  1  one-cycle pulse: branch resolved taken.
REQ-012 SHALL have port flush  out  1  squash younger instructions.
REQ-013 SHALL have port busy  out  1  high when state is not IDLE.

Function
REQ-014 flags SHALL load {alu_neg,alu_zero,alu_carry,alu_ovf} on a clock edge when set_flags=1 and stall=0; otherwise hold.
REQ-015 Effective flags for resolution SHALL be live ALU flags when set_flags=1 in the same cycle (forwarding), else registered flags.
REQ-016 Taken SHALL be: B,BR always; CBZ iff cbz_zero=1; CBNZ iff cbz_zero=0; B_EQ iff Z; B_LT iff N!=V; B_GE iff N==V; NONE and codes >7 never.
REQ-017 br_taken SHALL be combinational in the resolving cycle, gated by br_valid, state IDLE and stall=0.
REQ-018 FSM states SHALL be IDLE and FLUSH; IDLE->FLUSH on br_taken; FLUSH holds for FLUSH_CYCLES cycles via a 2-bit down-counter, then ->IDLE.
REQ-019 flush SHALL be high in the br_taken cycle and every FLUSH cycle (total FLUSH_CYCLES+1 cycles).
REQ-020 In FLUSH, br_valid SHALL be ignored (squashed branch never resolves); set_flags SHALL also be ignored.
REQ-021 stall=1 SHALL freeze state, counter and flags; br_taken=0 while stalled; flush holds its value.
REQ-022 Not-taken branch SHALL leave state IDLE with br_taken=0, flush=0.

Reset
REQ-023 reset SHALL take priority over stall and all inputs.
REQ-024 On reset: flags=4'b0000, state=IDLE, counter=0, br_taken=0, flush=0, busy=0 from the following cycle; a reset during FLUSH aborts it.

Configuration
REQ-025 With BRANCH_STATS_EN defined, SHALL add outputs br_count and taken_count (32 bits each), incrementing per resolved branch / per taken branch, wrapping at 2^32, cleared by reset, frozen by stall.
REQ-026 Without BRANCH_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-027 br_type_t, state enum, flag bit indices (N=3,Z=2,C=1,V=0) SHALL live in shared package cpu_pkg.
REQ-028 Condition evaluation SHALL be one combinational sub-module branch_cond (br_type, flags, cbz_zero -> taken); FSM, flag register and counters stay in branch_flag_unit.

Verification
REQ-029 reset; set_flags=1 with ALU flags 4'b0100 -> flags=4'b0100 next cycle; flags unchanged while set_flags=0.
REQ-030 Same cycle set_flags=1, alu_neg=1, alu_ovf=0, br_type=B_LT, br_valid=1 -> br_taken=1 (forwarded), flush high 2 cycles with FLUSH_CYCLES=1.
REQ-031 CBZ with cbz_zero=0 -> br_taken=0, flush=0; CBNZ with cbz_zero=0 -> br_taken=1, busy=1 next cycle.
REQ-032 FLUSH_CYCLES=3: taken B then br_valid=1 B on each following cycle -> exactly one br_taken pulse, flush high 4 cycles, busy high 3.
REQ-033 stall=1 for 2 cycles during FLUSH -> flush extended by 2 cycles, counter unchanged; reset asserted mid-FLUSH -> busy=0, flush=0 next cycle.
REQ-034 BRANCH_STATS_EN: 5 branches, 3 taken -> br_count=5, taken_count=3; preload 32'hFFFFFFFF -> wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the branch/flag unit: branch encodings, FSM states and the
// NZCV bit positions used by the flag register and the condition evaluator.
package cpu_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_B    = 3'd1,
      BR_BR   = 3'd2,
      BR_CBZ  = 3'd3,
      BR_CBNZ = 3'd4,
      BR_B_LT = 3'd5,
      BR_B_EQ = 3'd6,
      BR_B_GE = 3'd7
   } br_type_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } bfu_state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_cond.sv
// Purely combinational branch condition evaluator: decides taken/not-taken
// from the branch type, the effective NZCV flags and the CBZ/CBNZ zero test.
module branch_cond
   import cpu_pkg::*;
(
   input  logic [2:0] br_type,
   input  logic [3:0] flags,
   input  logic       cbz_zero,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (br_type_t'(br_type))
         BR_B, BR_BR: taken = 1'b1;
         BR_CBZ:      taken = cbz_zero;
         BR_CBNZ:     taken = ~cbz_zero;
         BR_B_EQ:     taken = flags[FLAG_Z];
         BR_B_LT:     taken = flags[FLAG_N] ^ flags[FLAG_V];
         BR_B_GE:     taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
         default:     taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_flag_unit.sv
// NZCV flag register, branch resolution and post-branch flush sequencer.
// Optional feature macro BRANCH_STATS_EN adds resolved/taken branch counters.
module branch_flag_unit
   import cpu_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        set_flags,
   input  logic        alu_neg,
   input  logic        alu_zero,
   input  logic        alu_carry,
   input  logic        alu_ovf,
   input  logic        br_valid,
   input  logic [2:0]  br_type,
   input  logic        cbz_zero,
   output logic [3:0]  flags,
   output logic        br_taken,
   output logic        flush,
   output logic        busy
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0] br_count,
   output logic [31:0] taken_count
`endif
);

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

   bfu_state_t state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] alu_flags;
   logic [3:0] eff_flags;
   logic       cond_taken;
   logic       idle;
   logic       resolve;

   assign alu_flags = {alu_neg, alu_zero, alu_carry, alu_ovf};
   assign idle      = (state_q == ST_IDLE);
   // Forward the EX flags so a compare and its dependent branch can share a cycle.
   assign eff_flags = set_flags ? alu_flags : flags;
   assign resolve   = br_valid && idle && !stall && !reset;
   assign br_taken  = resolve && cond_taken;
   assign flush     = br_taken || !idle;
   assign busy      = !idle;

   branch_cond u_cond (
      .br_type  (br_type),
      .flags    (eff_flags),
      .cbz_zero (cbz_zero),
      .taken    (cond_taken)
   );

   // Instructions being squashed during a flush must not update the flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= 4'b0000;
      end else if (!stall && set_flags && idle) begin
         flags <= alu_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
      end else if (!stall) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (br_taken) begin
               state_d = ST_FLUSH;
               cnt_d   = FLUSH_LOAD;
            end
         end
         ST_FLUSH: begin
            if (cnt_q <= 2'd1) begin
               state_d = ST_IDLE;
               cnt_d   = 2'd0;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
         end
      endcase
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         br_count    <= 32'd0;
         taken_count <= 32'd0;
      end else begin
         if (resolve) br_count <= br_count + 32'd1;
         if (br_taken) taken_count <= taken_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_flag_unit.sv
// Scoreboard bench for branch_flag_unit: directed vectors drive two instances
// (FLUSH_CYCLES=1 and 3); a negedge monitor pops expected outputs and compares.
module tb_branch_flag_unit;

   typedef struct {
      int         idx;
      bit         sel;
      logic [3:0] flags;
      logic       taken;
      logic       flush;
      logic       busy;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset1 = 1'b1;
   logic       reset3 = 1'b1;
   logic       stall = 1'b0;
   logic       set_flags = 1'b0;
   logic       alu_neg = 1'b0;
   logic       alu_zero = 1'b0;
   logic       alu_carry = 1'b0;
   logic       alu_ovf = 1'b0;
   logic       br_valid = 1'b0;
   logic [2:0] br_type = 3'd0;
   logic       cbz_zero = 1'b0;

   logic [3:0] flags1, flags3;
   logic       br_taken1, br_taken3;
   logic       flush1, flush3;
   logic       busy1, busy3;
`ifdef BRANCH_STATS_EN
   logic [31:0] br_count1, taken_count1, br_count3, taken_count3;
`endif

   exp_t sb_q[$];
   int   vec_idx = 0;
   int   n_compared = 0;
   int   n_mismatched = 0;

   always #5 clk = ~clk;

   branch_flag_unit #(.FLUSH_CYCLES(1)) dut1 (
      .clk       (clk),
      .reset     (reset1),
      .stall     (stall),
      .set_flags (set_flags),
      .alu_neg   (alu_neg),
      .alu_zero  (alu_zero),
      .alu_carry (alu_carry),
      .alu_ovf   (alu_ovf),
      .br_valid  (br_valid),
      .br_type   (br_type),
      .cbz_zero  (cbz_zero),
      .flags     (flags1),
      .br_taken  (br_taken1),
      .flush     (flush1),
      .busy      (busy1)
`ifdef BRANCH_STATS_EN
      ,
      .br_count    (br_count1),
      .taken_count (taken_count1)
`endif
   );

   branch_flag_unit #(.FLUSH_CYCLES(3)) dut3 (
      .clk       (clk),
      .reset     (reset3),
      .stall     (stall),
      .set_flags (set_flags),
      .alu_neg   (alu_neg),
      .alu_zero  (alu_zero),
      .alu_carry (alu_carry),
      .alu_ovf   (alu_ovf),
      .br_valid  (br_valid),
      .br_type   (br_type),
      .cbz_zero  (cbz_zero),
      .flags     (flags3),
      .br_taken  (br_taken3),
      .flush     (flush3),
      .busy      (busy3)
`ifdef BRANCH_STATS_EN
      ,
      .br_count    (br_count3),
      .taken_count (taken_count3)
`endif
   );

   task automatic checkOutput(input int idx, input string what,
                              input logic [31:0] act, input logic [31:0] exp_v);
      n_compared++;
      if (act !== exp_v) begin
         n_mismatched++;
         $display("[TB] FAIL vec %0d %s: got %h expected %h", idx, what, act, exp_v);
      end
   endtask

   // One vector per cycle; the instance not under test is held in reset.
   task automatic applyStimulus(input bit sel, input logic rst, input logic stl,
                                input logic sf, input logic [3:0] alu,
                                input logic bv, input logic [2:0] bt, input logic cz,
                                input logic [3:0] ef, input logic et,
                                input logic efl, input logic eb);
      exp_t e;
      @(posedge clk);
      #1;
      reset1 = sel ? 1'b1 : rst;
      reset3 = sel ? rst : 1'b1;
      stall = stl;
      set_flags = sf;
      {alu_neg, alu_zero, alu_carry, alu_ovf} = alu;
      br_valid = bv;
      br_type = bt;
      cbz_zero = cz;
      e.idx = vec_idx;
      e.sel = sel;
      e.flags = ef;
      e.taken = et;
      e.flush = efl;
      e.busy = eb;
      sb_q.push_back(e);
      vec_idx++;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (!e.sel) begin
            checkOutput(e.idx, "flags", {28'd0, flags1}, {28'd0, e.flags});
            checkOutput(e.idx, "br_taken", {31'd0, br_taken1}, {31'd0, e.taken});
            checkOutput(e.idx, "flush", {31'd0, flush1}, {31'd0, e.flush});
            checkOutput(e.idx, "busy", {31'd0, busy1}, {31'd0, e.busy});
         end else begin
            checkOutput(e.idx, "flags", {28'd0, flags3}, {28'd0, e.flags});
            checkOutput(e.idx, "br_taken", {31'd0, br_taken3}, {31'd0, e.taken});
            checkOutput(e.idx, "flush", {31'd0, flush3}, {31'd0, e.flush});
            checkOutput(e.idx, "busy", {31'd0, busy3}, {31'd0, e.busy});
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);

      // FLUSH_CYCLES=1: flag load/hold, forwarding, CBZ/CBNZ, stall, reset
      applyStimulus(0, 1, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 4'b0100, 0, 3'd0, 0, 4'b0000, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 4'b1011, 0, 3'd0, 0, 4'b0100, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 4'b1111, 0, 3'd0, 0, 4'b0100, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 4'b1000, 1, 3'd5, 0, 4'b0100, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b1000, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b1000, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 4'b0000, 1, 3'd3, 0, 4'b1000, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 4'b0000, 1, 3'd4, 0, 4'b1000, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b1000, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b1000, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 4'b0000, 1, 3'd6, 0, 4'b1000, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 4'b0000, 1, 3'd7, 0, 4'b1000, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 4'b1001, 1, 3'd7, 0, 4'b1000, 1, 1, 0);
      applyStimulus(0, 0, 0, 1, 4'b0100, 1, 3'd1, 0, 4'b1001, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b1001, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 4'b0000, 1, 3'd1, 0, 4'b1001, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 4'b0010, 1, 3'd1, 0, 4'b1001, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b1001, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 4'b0000, 1, 3'd0, 0, 4'b1001, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 4'b0000, 1, 3'd2, 0, 4'b1001, 1, 1, 0);
      applyStimulus(0, 0, 1, 0, 4'b0000, 0, 3'd0, 0, 4'b1001, 0, 1, 1);
      applyStimulus(0, 0, 1, 0, 4'b0000, 0, 3'd0, 0, 4'b1001, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b1001, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b1001, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 4'b0100, 1, 3'd6, 0, 4'b1001, 1, 1, 0);
      applyStimulus(0, 1, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0100, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 0, 0);

      // FLUSH_CYCLES=3: squashed branches, stall extension, reset abort, mixed types
      applyStimulus(1, 1, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 4'b0000, 1, 3'd1, 0, 4'b0000, 1, 1, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 0, 0, 0, 4'b0000, 1, 3'd1, 0, 4'b0000, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 4'b0000, 1, 3'd1, 0, 4'b0000, 1, 1, 0);
      applyStimulus(1, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 1, 1);
      applyStimulus(1, 0, 1, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 1, 1);
      applyStimulus(1, 0, 1, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 4'b0000, 1, 3'd1, 0, 4'b0000, 1, 1, 0);
      applyStimulus(1, 1, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 4'b0000, 1, 3'd1, 0, 4'b0000, 1, 1, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 4'b0000, 1, 3'd3, 0, 4'b0000, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 4'b0000, 1, 3'd6, 0, 4'b0000, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 4'b0000, 1, 3'd3, 1, 4'b0000, 1, 1, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 4'b0000, 1, 3'd7, 0, 4'b0000, 1, 1, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 4'b0000, 0, 3'd0, 0, 4'b0000, 0, 0, 0);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++)
         @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
      end

`ifdef BRANCH_STATS_EN
      checkOutput(-1, "br_count", br_count3, 32'd5);
      checkOutput(-1, "taken_count", taken_count3, 32'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
